// File: rtl/pll_drp_ctrl.sv
// PLL reconfiguration controller. It takes a stream of read-modify-write entries
// (addr, keep-mask, data, last). For each entry it reads the DRP register and writes
// back the merged value. The PLL is held in reset for the whole sequence. After the
// last write, reset is released and the controller waits for lock. Every DRP
// handshake and the lock wait are bounded by a single shared timeout counter.
//
// Ports:
//   clk_in0, reset_n            clock (also PLL DCLK), async active-low reset
//   req_valid/req_ready         entry handshake
//   req_addr/mask/data/last     entry payload; mask bit 1 keeps the current value
//   drp_daddr/den/dwe/di        DRP command to the PLL
//   drp_do/drp_drdy             DRP response from the PLL
//   pll_rst, pll_locked         PLL reset (active-high) and lock indication
//   busy, done, error           sequence status
module pll_drp_ctrl #(
  parameter int unsigned RST_HOLD     = 4,
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic        clk_in0,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_addr,
  input  logic [15:0] req_mask,
  input  logic [15:0] req_data,
  input  logic        req_last,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned TMaxA = (RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT;
  localparam int unsigned TMax  = (TMaxA > LOCK_TIMEOUT) ? TMaxA : LOCK_TIMEOUT;
  localparam int unsigned TW    = $clog2(TMax + 2);

  typedef enum logic [3:0] {
    StIdle, StRstHold, StRdReq, StRdWait, StWrReq,
    StWrWait, StGetNext, StLockWait, StDone, StErr
  } state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [6:0]     addr_q, addr_d;
  logic [15:0]    mask_q, mask_d;
  logic [15:0]    data_q, data_d;
  logic           last_q, last_d;
  logic [15:0]    wdata_q, wdata_d;
  logic           ready_q, ready_d;
  logic           pll_rst_q, pll_rst_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           error_q, error_d;
  logic           xfer;
  logic [31:0]    elapsed;

  assign xfer    = req_valid && ready_q;
  // Cycles spent in the current state, counting the present one.
  assign elapsed = 32'(timer_q) + 32'd1;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    data_d    = data_q;
    last_d    = last_q;
    wdata_d   = wdata_q;
    pll_rst_d = pll_rst_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;

    if (xfer) begin
      addr_d = req_addr;
      mask_d = req_mask;
      data_d = req_data;
      last_d = req_last;
    end

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          state_d   = StRstHold;
          pll_rst_d = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
        end
      end
      StRstHold: begin
        if (elapsed >= RST_HOLD) state_d = StRdReq;
      end
      StRdReq: state_d = StRdWait;
      StRdWait: begin
        if (drp_drdy) begin
          wdata_d = (drp_do & mask_q) | (data_q & ~mask_q);
          state_d = StWrReq;
        end else if (elapsed >= DRDY_TIMEOUT) begin
          state_d = StErr;
        end
      end
      StWrReq: state_d = StWrWait;
      StWrWait: begin
        if (drp_drdy) begin
          if (last_q) begin
            state_d   = StLockWait;
            pll_rst_d = 1'b0;
          end else begin
            state_d = StGetNext;
          end
        end else if (elapsed >= DRDY_TIMEOUT) begin
          state_d = StErr;
        end
      end
      StGetNext: begin
        if (xfer) state_d = StRdReq;
      end
      StLockWait: begin
        if (pll_locked) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (elapsed >= LOCK_TIMEOUT) begin
          state_d = StErr;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Status for the error state is applied on the entering edge.
    if (state_d == StErr && state_q != StErr) begin
      pll_rst_d = 1'b0;
      busy_d    = 1'b0;
      error_d   = 1'b1;
    end

    // Cleared on every state entry; saturates instead of wrapping.
    if (state_d != state_q)  timer_d = '0;
    else if (&timer_q)       timer_d = timer_q;
    else                     timer_d = timer_q + TW'(1);

    // Registered so req_ready stays low while reset is asserted.
    ready_d = (state_d == StIdle) || (state_d == StGetNext);
  end

  always_ff @(posedge clk_in0 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      wdata_q   <= '0;
      ready_q   <= 1'b0;
      pll_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      last_q    <= last_d;
      wdata_q   <= wdata_d;
      ready_q   <= ready_d;
      pll_rst_q <= pll_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // DRP strobes are single-cycle request states; address and data are zeroed when idle.
  assign drp_den   = (state_q == StRdReq) || (state_q == StWrReq);
  assign drp_dwe   = (state_q == StWrReq);
  assign drp_daddr = drp_den ? addr_q : '0;
  assign drp_di    = drp_dwe ? wdata_q : '0;

  assign req_ready = ready_q;
  assign pll_rst   = pll_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
